// File: rtl/irq_pkg.sv
// irq_pkg: shared addresses, source bit indices and default source count for the interrupt controller
package irq_pkg;
  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;
  localparam int NSRC_DEFAULT = 5;
  localparam int SRC_VBLANK = 0;
  localparam int SRC_STAT = 1;
  localparam int SRC_TIMER = 2;
  localparam int SRC_SERIAL = 3;
  localparam int SRC_JOYPAD = 4;
endpackage

// File: rtl/irq_if.sv
// irq_if: CPU memory bus as seen by the interrupt controller
interface irq_if;
  logic [15:0] A;
  logic [7:0] D_IN;
  logic [7:0] D_OUT;
  logic D_OE;
  logic RD;
  logic WR;
  logic MREQ;
  modport master (output A, D_IN, RD, WR, MREQ, input D_OUT, D_OE);
  modport slave (input A, D_IN, RD, WR, MREQ, output D_OUT, D_OE);
endinterface

// File: rtl/irq_edge_det.sv
// irq_edge_det: per-bit rising-edge detector against a registered previous sample
module irq_edge_det #(
  parameter int W = 1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);
  logic [W-1:0] prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) prev <= {W{RST_VAL}};
    else prev <= d;
  assign rise = d & ~prev;
endmodule

// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: IF/IE registers with edge-captured sources, acknowledge clearing and CPU bus access
module interrupt_ctrl
  import irq_pkg::*;
#(
  parameter int NSRC = NSRC_DEFAULT
) (
  input  logic            CLK,
  input  logic            RESET,
  irq_if.slave            bus,
  input  logic [NSRC-1:0] IRQ_SRC,
  output logic [7:0]      CPU_IRQ_TRIG,
  input  logic [7:0]      CPU_IRQ_ACK,
  output logic            WAKE
);
  localparam logic [7:0] MASK = 8'((9'd1 << NSRC) - 9'd1);
  logic [NSRC-1:0] src_rise;
  logic wr_rise, commit;
  logic [7:0] if_q, ie_q, if_nxt;
  irq_edge_det #(.W(NSRC)) u_src (.clk(CLK), .rst(RESET), .d(IRQ_SRC), .rise(src_rise));
  // Write strobe counts as already seen after reset so an aborted access needs a fresh WR edge
  irq_edge_det #(.W(1), .RST_VAL(1'b1)) u_wr (.clk(CLK), .rst(RESET), .d(bus.MREQ & bus.WR), .rise(wr_rise));
  always_comb begin
    commit = wr_rise & ~bus.RD;
    if_nxt = (((commit && bus.A == ADDR_IF) ? bus.D_IN : if_q) & ~CPU_IRQ_ACK & MASK) | 8'(src_rise);
    CPU_IRQ_TRIG = if_q & ie_q;
    WAKE = |CPU_IRQ_TRIG;
    bus.D_OE = bus.MREQ & bus.RD & (bus.A == ADDR_IF | bus.A == ADDR_IE);
    bus.D_OUT = bus.A == ADDR_IF ? (~MASK | if_q) : bus.A == ADDR_IE ? ie_q : 8'h00;
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      if_q <= 8'h00;
      ie_q <= 8'h00;
    end else begin
      if_q <= if_nxt;
      if (commit && bus.A == ADDR_IE) ie_q <= bus.D_IN;
    end
endmodule

// File: tb/tb_interrupt_ctrl.sv
// tb_interrupt_ctrl: directed and randomized checks of interrupt_ctrl against a behavioural model
module tb_interrupt_ctrl;
  import irq_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] src;
  logic [7:0] ack, trig;
  logic wake;
  int checks = 0, failures = 0;
  logic [7:0] if_m, ie_m;
  logic [4:0] sp_m;
  bit armed;
  irq_if bus();
  interrupt_ctrl dut (.CLK(clk), .RESET(rst), .bus(bus), .IRQ_SRC(src), .CPU_IRQ_TRIG(trig), .CPU_IRQ_ACK(ack), .WAKE(wake));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] m_dout();
    if (bus.A == 16'hFF0F) return 8'hE0 | if_m;
    if (bus.A == 16'hFFFF) return ie_m;
    return 8'h00;
  endfunction
  task automatic check_all();
    logic [7:0] t;
    t = if_m & ie_m & 8'h1F;
    chk("trig", trig, t);
    chk("wake", {7'b0, wake}, {7'b0, t != 0});
    chk("d_oe", {7'b0, bus.D_OE}, {7'b0, bus.MREQ && bus.RD && (bus.A == 16'hFF0F || bus.A == 16'hFFFF)});
    chk("d_out", bus.D_OUT, m_dout());
  endtask
  task automatic model_reset();
    if_m = 0; ie_m = 0; sp_m = 0; armed = 0;
  endtask
  // One clock: the model decides what the cycle does from the inputs present before the edge
  task automatic cyc();
    logic [7:0] nif, nie;
    bit w;
    w = bus.MREQ && bus.WR && !bus.RD && armed;
    nif = if_m;
    nie = ie_m;
    if (w && bus.A == 16'hFF0F) nif = {3'b0, bus.D_IN[4:0]};
    if (w && bus.A == 16'hFFFF) nie = bus.D_IN;
    for (int b = 0; b < 5; b++) begin
      if (ack[b]) nif[b] = 1'b0;
      if (src[b] && !sp_m[b]) nif[b] = 1'b1;
    end
    armed = !(bus.MREQ && bus.WR);
    sp_m = src;
    @(posedge clk);
    #1;
    if_m = nif;
    ie_m = nie;
    check_all();
  endtask
  task automatic idle();
    bus.MREQ = 0; bus.WR = 0; bus.RD = 0;
  endtask
  task automatic wr(logic [15:0] a, logic [7:0] d);
    bus.A = a; bus.D_IN = d; bus.MREQ = 1; bus.WR = 1; bus.RD = 0;
    cyc();
    idle();
    cyc();
  endtask
  task automatic rd_chk(string tag, logic [15:0] a, logic [7:0] exp);
    bus.A = a; bus.MREQ = 1; bus.RD = 1;
    #1;
    chk(tag, bus.D_OUT, exp);
    chk({tag, "_oe"}, {7'b0, bus.D_OE}, 8'h01);
    idle();
  endtask
  initial begin
    rst = 1; src = 5'b00010; ack = 0; bus.A = 0; bus.D_IN = 0;
    idle();
    model_reset();
    #12;
    chk("rst_trig", trig, 8'h00);
    chk("rst_wake", {7'b0, wake}, 8'h00);
    chk("rst_doe", {7'b0, bus.D_OE}, 8'h00);
    @(negedge clk);
    rst = 0;
    cyc();
    rd_chk("held_src", 16'hFF0F, 8'hE2);
    src = 0;
    wr(16'hFF0F, 8'h00);
    wr(16'hFFFF, 8'h05);
    rd_chk("ie_rd", 16'hFFFF, 8'h05);
    src[2] = 1;
    cyc();
    chk("timer_trig", trig, 8'h04);
    chk("timer_wake", {7'b0, wake}, 8'h01);
    rd_chk("timer_if", 16'hFF0F, 8'hE4);
    src = 0;
    wr(16'hFFFF, 8'h00);
    wr(16'hFF0F, 8'h00);
    src[0] = 1;
    cyc();
    rd_chk("vbl_if", 16'hFF0F, 8'hE1);
    chk("vbl_trig", trig, 8'h00);
    chk("vbl_wake", {7'b0, wake}, 8'h00);
    src = 0;
    wr(16'hFF0F, 8'h04);
    wr(16'hFFFF, 8'h1F);
    chk("pre_ack", trig, 8'h04);
    ack = 8'h04;
    cyc();
    ack = 0;
    chk("ack_trig", trig, 8'h00);
    rd_chk("ack_if", 16'hFF0F, 8'hE0);
    src[0] = 1;
    cyc();
    src[0] = 0;
    cyc();
    src[0] = 1; ack = 8'h01;
    cyc();
    ack = 0; src = 0;
    rd_chk("edge_wins", 16'hFF0F, 8'hE1);
    wr(16'hFF0F, 8'h00);
    bus.A = 16'hFF0F; bus.D_IN = 8'h00; bus.MREQ = 1; bus.WR = 1;
    cyc();
    src[3] = 1;
    cyc();
    cyc();
    idle();
    src = 0;
    rd_chk("single_commit", 16'hFF0F, 8'hE8);
    bus.A = 16'hFFFF; bus.D_IN = 8'hAA; bus.MREQ = 1; bus.WR = 1; bus.RD = 1;
    cyc();
    idle();
    cyc();
    rd_chk("rdwr_ignored", 16'hFFFF, 8'h1F);
    wr(16'hFFFF, 8'hFF);
    wr(16'hFF0F, 8'h1F);
    chk("pre_rst", trig, 8'h1F);
    bus.A = 16'hFF0F;
    #2;
    rst = 1;
    #1;
    chk("async_trig", trig, 8'h00);
    chk("async_wake", {7'b0, wake}, 8'h00);
    chk("async_doe", {7'b0, bus.D_OE}, 8'h00);
    chk("async_dout", bus.D_OUT, 8'hE0);
    model_reset();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 600; i++) begin
      bus.MREQ = $urandom_range(0, 3) != 0;
      bus.WR = $urandom_range(0, 2) == 0;
      bus.RD = $urandom_range(0, 3) == 0;
      case ($urandom_range(0, 2))
        0: bus.A = 16'hFF0F;
        1: bus.A = 16'hFFFF;
        default: bus.A = 16'($urandom);
      endcase
      bus.D_IN = 8'($urandom);
      if ($urandom_range(0, 2) == 0) src = 5'($urandom);
      ack = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'h00;
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
